// File: rtl/debug_pkg.sv
// Shared definitions for the debug command path: opcode values, the
// parser state encoding and the UART bit timing used to size timeouts.
package debug_pkg;

  localparam logic [7:0] OP_NONE    = 8'hff;
  localparam logic [7:0] OP_SIGNAL  = 8'h01;
  localparam logic [7:0] OP_OK      = 8'h02;
  localparam logic [7:0] OP_PING    = 8'h03;
  localparam logic [7:0] OP_PAUSE   = 8'h04;
  localparam logic [7:0] OP_RESUME  = 8'h05;
  localparam logic [7:0] OP_NEXT    = 8'h06;
  localparam logic [7:0] OP_PROGRAM = 8'h07;

  localparam int UART_CLKS_PER_BIT = 868;

  typedef enum logic {
    IDLE       = 1'b0,
    BP_COLLECT = 1'b1
  } state_t;

endpackage

// File: rtl/dbg_timeout_counter.sv
// Idle-cycle watchdog for breakpoint collection. Counts enabled cycles
// since the last clear and flags expiry once TIMEOUT_CYCLES-1 is reached.
module dbg_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  // Count idle cycles, holding at the terminal value until cleared
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = enable && !clear && (count == LAST);

endmodule

// File: rtl/debug_cmd_parser.sv
// Debug UART command parser: turns received bytes into one-cycle strobes
// for the CPU debug unit, collects the little-endian breakpoint address
// after OP_RESUME and raises an OP_OK response request on OP_PING.
// Optional statistics counters are enabled with `define DBG_CMD_STATS_EN.
// BP_BYTES is limited to 1..4 since bp_addr is 32 bits wide.
module debug_cmd_parser
  import debug_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int BP_BYTES       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        cmd_pause,
  output logic        cmd_resume,
  output logic [31:0] bp_addr,
  output logic        bp_en,
  output logic        cmd_next,
  output logic        cmd_program,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        err_unknown,
  output logic        err_timeout,
  output logic        busy
`ifdef DBG_CMD_STATS_EN
  ,
  output logic [15:0] cmd_count,
  output logic [15:0] err_count
`endif
);

  state_t      state, state_nxt;
  logic [1:0]  byte_cnt, byte_cnt_nxt;
  logic [31:0] bp_shift, shift_nxt;
  logic        pause_nxt, resume_nxt, next_nxt, program_nxt;
  logic        unknown_nxt, timeout_nxt, ping_req, tx_valid_nxt;
  logic        tmr_clear, tmr_enable, tmr_expire;

  assign tmr_clear  = (state == IDLE) || rx_valid;
  assign tmr_enable = (state == BP_COLLECT);

  dbg_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expire (tmr_expire)
  );

  // Parser state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Opcode decode, breakpoint byte placement and response-pending update
  always_comb begin
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    shift_nxt    = bp_shift;
    pause_nxt    = 1'b0;
    resume_nxt   = 1'b0;
    next_nxt     = 1'b0;
    program_nxt  = 1'b0;
    unknown_nxt  = 1'b0;
    timeout_nxt  = 1'b0;
    ping_req     = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid) begin
          case (rx_data)
            OP_PAUSE:   pause_nxt   = 1'b1;
            OP_NEXT:    next_nxt    = 1'b1;
            OP_PROGRAM: program_nxt = 1'b1;
            OP_PING:    ping_req    = 1'b1;
            OP_RESUME: begin
              state_nxt    = BP_COLLECT;
              byte_cnt_nxt = '0;
            end
            OP_NONE: ;
            default:    unknown_nxt = 1'b1;
          endcase
        end
      end
      BP_COLLECT: begin
        if (rx_valid) begin
          shift_nxt[{byte_cnt, 3'b000} +: 8] = rx_data;
          if (byte_cnt == 2'(BP_BYTES - 1)) begin
            resume_nxt   = 1'b1;
            state_nxt    = IDLE;
            byte_cnt_nxt = '0;
          end else begin
            byte_cnt_nxt = byte_cnt + 1'b1;
          end
        end else if (tmr_expire) begin
          timeout_nxt  = 1'b1;
          state_nxt    = IDLE;
          byte_cnt_nxt = '0;
        end
      end
    endcase
    tx_valid_nxt = ping_req || (tx_valid && !tx_ready);
  end

  // Registered strobes, breakpoint registers and response flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt    <= '0;
      bp_shift    <= '0;
      bp_addr     <= '0;
      bp_en       <= 1'b0;
      cmd_pause   <= 1'b0;
      cmd_resume  <= 1'b0;
      cmd_next    <= 1'b0;
      cmd_program <= 1'b0;
      err_unknown <= 1'b0;
      err_timeout <= 1'b0;
      tx_valid    <= 1'b0;
    end else begin
      byte_cnt    <= byte_cnt_nxt;
      bp_shift    <= shift_nxt;
      cmd_pause   <= pause_nxt;
      cmd_resume  <= resume_nxt;
      cmd_next    <= next_nxt;
      cmd_program <= program_nxt;
      err_unknown <= unknown_nxt;
      err_timeout <= timeout_nxt;
      tx_valid    <= tx_valid_nxt;
      if (resume_nxt) begin
        bp_addr <= shift_nxt;
        bp_en   <= |shift_nxt;
      end
    end
  end

  assign tx_data = OP_OK;
  assign busy    = (state == BP_COLLECT);

`ifdef DBG_CMD_STATS_EN
  logic cmd_inc, err_inc;

  // A PING counts only when it actually schedules a new OK byte
  assign cmd_inc = pause_nxt || resume_nxt || next_nxt || program_nxt ||
                   (ping_req && (!tx_valid || tx_ready));
  assign err_inc = unknown_nxt || timeout_nxt;

  // Saturating command and error counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_count <= '0;
      err_count <= '0;
    end else begin
      if (cmd_inc && (cmd_count != 16'hffff)) cmd_count <= cmd_count + 1'b1;
      if (err_inc && (err_count != 16'hffff)) err_count <= err_count + 1'b1;
    end
  end
`else
`endif

endmodule

// File: tb/tb_debug_cmd_parser.sv
// Self-checking bench for debug_cmd_parser: directed scenarios plus
// randomized byte streams compared every cycle against a transaction-level
// model of the command protocol.
module tb_debug_cmd_parser;

  localparam int TMO = 50;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic        cmd_pause, cmd_resume, bp_en, cmd_next, cmd_program;
  logic        tx_valid, err_unknown, err_timeout, busy;
  logic [31:0] bp_addr;
  logic [7:0]  tx_data;
`ifdef DBG_CMD_STATS_EN
  logic [15:0] cmd_count, err_count;
`endif

  debug_cmd_parser #(
    .TIMEOUT_CYCLES(TMO),
    .BP_BYTES(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .cmd_pause(cmd_pause), .cmd_resume(cmd_resume), .bp_addr(bp_addr),
    .bp_en(bp_en), .cmd_next(cmd_next), .cmd_program(cmd_program),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .err_unknown(err_unknown), .err_timeout(err_timeout), .busy(busy)
`ifdef DBG_CMD_STATS_EN
    , .cmd_count(cmd_count), .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;
  bit rand_ready = 1'b0;

  // Expected outputs produced by the model
  logic        exp_pause, exp_resume, exp_next, exp_program;
  logic        exp_unknown, exp_timeout, exp_tx_valid, exp_busy, exp_bp_en;
  logic [31:0] exp_bp_addr;
  int          exp_cmd_count, exp_err_count;

  // Model bookkeeping
  bit          m_collect;
  int          m_nbytes;
  int          m_silence;
  logic [7:0]  m_bytes [4];

  task automatic cmpVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of the protocol described in command-level terms
  task automatic modelStep();
    logic old_tx;
    logic ping;
    if (!rst_n) begin
      {exp_pause, exp_resume, exp_next, exp_program} = '0;
      {exp_unknown, exp_timeout, exp_tx_valid, exp_busy, exp_bp_en} = '0;
      exp_bp_addr = '0;
      exp_cmd_count = 0;
      exp_err_count = 0;
      m_collect = 1'b0;
      m_nbytes = 0;
      m_silence = 0;
      return;
    end
    old_tx = exp_tx_valid;
    ping = 1'b0;
    {exp_pause, exp_resume, exp_next, exp_program, exp_unknown, exp_timeout} = '0;
    if (!m_collect) begin
      if (rx_valid) begin
        case (rx_data)
          8'h04: exp_pause = 1'b1;
          8'h06: exp_next = 1'b1;
          8'h07: exp_program = 1'b1;
          8'h03: ping = 1'b1;
          8'h05: begin m_collect = 1'b1; m_nbytes = 0; m_silence = 0; end
          8'hff: ;
          default: exp_unknown = 1'b1;
        endcase
      end
    end else if (rx_valid) begin
      m_bytes[m_nbytes] = rx_data;
      m_nbytes++;
      m_silence = 0;
      if (m_nbytes == 4) begin
        exp_bp_addr = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
        exp_bp_en = (exp_bp_addr != 0);
        exp_resume = 1'b1;
        m_collect = 1'b0;
      end
    end else begin
      m_silence++;
      if (m_silence == TMO) begin
        exp_timeout = 1'b1;
        m_collect = 1'b0;
      end
    end
    exp_tx_valid = ping || (old_tx && !tx_ready);
    exp_busy = m_collect;
    if ((exp_pause || exp_resume || exp_next || exp_program ||
         (ping && (!old_tx || tx_ready))) && exp_cmd_count < 65535)
      exp_cmd_count++;
    if ((exp_unknown || exp_timeout) && exp_err_count < 65535)
      exp_err_count++;
  endtask

  // Compare all outputs to the model
  task automatic checkOutput();
    cmpVal("cmd_pause", 32'(cmd_pause), 32'(exp_pause));
    cmpVal("cmd_resume", 32'(cmd_resume), 32'(exp_resume));
    cmpVal("cmd_next", 32'(cmd_next), 32'(exp_next));
    cmpVal("cmd_program", 32'(cmd_program), 32'(exp_program));
    cmpVal("err_unknown", 32'(err_unknown), 32'(exp_unknown));
    cmpVal("err_timeout", 32'(err_timeout), 32'(exp_timeout));
    cmpVal("tx_valid", 32'(tx_valid), 32'(exp_tx_valid));
    cmpVal("tx_data", 32'(tx_data), 32'h02);
    cmpVal("busy", 32'(busy), 32'(exp_busy));
    cmpVal("bp_addr", bp_addr, exp_bp_addr);
    cmpVal("bp_en", 32'(bp_en), 32'(exp_bp_en));
`ifdef DBG_CMD_STATS_EN
    cmpVal("cmd_count", 32'(cmd_count), 32'(exp_cmd_count));
    cmpVal("err_count", 32'(err_count), 32'(exp_err_count));
`endif
  endtask

  // Model advances on every active edge
  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Compare process samples on the falling edge
  initial forever begin
    @(negedge clk);
    if (check_en) checkOutput();
  end

  // Move to the next falling edge, optionally randomizing tx_ready
  task automatic stepCycle();
    @(negedge clk);
    if (rand_ready) tx_ready = 1'($urandom_range(0, 1));
  endtask

  // Present one byte for one cycle, then idle for gap cycles
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_valid = 1'b1;
    stepCycle();
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (gap) stepCycle();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    int handshakes;
    int g;
    logic [7:0] b;
    logic [7:0] ops [8];
    ops = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hff, 8'h01, 8'h02};

    repeat (3) @(negedge clk);
    check_en = 1'b1;
    cmpVal("reset_busy", 32'(busy), 32'h0);
    cmpVal("reset_bp_addr", bp_addr, 32'h0);
    cmpVal("reset_tx_valid", 32'(tx_valid), 32'h0);
    rst_n = 1'b1;
    stepCycle();

    $display("[TB] pause strobe");
    applyStimulus(8'h04, 0);
    cmpVal("pause_hi", 32'(cmd_pause), 32'h1);
    cmpVal("pause_no_next", 32'(cmd_next), 32'h0);
    stepCycle();
    cmpVal("pause_lo", 32'(cmd_pause), 32'h0);

    $display("[TB] resume with breakpoint 4");
    applyStimulus(8'h05, 0);
    cmpVal("busy_after_05", 32'(busy), 32'h1);
    stepCycle();
    applyStimulus(8'h04, 1);
    applyStimulus(8'h00, 1);
    applyStimulus(8'h00, 1);
    applyStimulus(8'h00, 0);
    cmpVal("resume_hi", 32'(cmd_resume), 32'h1);
    cmpVal("resume_addr", bp_addr, 32'h4);
    cmpVal("resume_en", 32'(bp_en), 32'h1);
    cmpVal("model_addr", exp_bp_addr, 32'h4);
    stepCycle();

    $display("[TB] breakpoint timeout");
    applyStimulus(8'h05, 1);
    applyStimulus(8'hdc, 0);
    waited = 0;
    while (!err_timeout && waited < 100) begin
      stepCycle();
      waited++;
    end
    cmpVal("timeout_latency", 32'(waited), 32'(TMO));
    cmpVal("timeout_busy", 32'(busy), 32'h0);
    cmpVal("timeout_addr_kept", bp_addr, 32'h4);
    stepCycle();

    $display("[TB] resume with zero address and two steps");
    applyStimulus(8'h05, 1);
    applyStimulus(8'h00, 1);
    applyStimulus(8'h00, 1);
    applyStimulus(8'h00, 1);
    applyStimulus(8'h00, 0);
    cmpVal("zero_resume", 32'(cmd_resume), 32'h1);
    cmpVal("zero_addr", bp_addr, 32'h0);
    cmpVal("zero_en", 32'(bp_en), 32'h0);
    stepCycle();
    applyStimulus(8'h06, 0);
    cmpVal("next1", 32'(cmd_next), 32'h1);
    stepCycle();
    applyStimulus(8'h06, 0);
    cmpVal("next2", 32'(cmd_next), 32'h1);
    stepCycle();

    $display("[TB] ping with stalled transmitter");
    tx_ready = 1'b0;
    applyStimulus(8'h03, 0);
    cmpVal("ping_valid", 32'(tx_valid), 32'h1);
    repeat (20) stepCycle();
    cmpVal("ping_held", 32'(tx_valid), 32'h1);
    cmpVal("ping_data", 32'(tx_data), 32'h02);
    applyStimulus(8'h03, 2);
    tx_ready = 1'b1;
    handshakes = 0;
    repeat (8) begin
      if (tx_valid && tx_ready) handshakes++;
      stepCycle();
    end
    cmpVal("ping_handshakes", 32'(handshakes), 32'h1);
    cmpVal("ping_done", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;

    $display("[TB] ignored, unknown, program and mid-collect reset");
    applyStimulus(8'hff, 0);
    cmpVal("ff_silent", 32'(err_unknown), 32'h0);
    stepCycle();
    applyStimulus(8'h01, 0);
    cmpVal("unknown_01", 32'(err_unknown), 32'h1);
    stepCycle();
    applyStimulus(8'h07, 0);
    cmpVal("program_07", 32'(cmd_program), 32'h1);
    stepCycle();
    applyStimulus(8'h05, 1);
    applyStimulus(8'h01, 0);
    cmpVal("busy_before_rst", 32'(busy), 32'h1);
    rst_n = 1'b0;
    stepCycle();
    rst_n = 1'b1;
    cmpVal("busy_after_rst", 32'(busy), 32'h0);
    cmpVal("addr_after_rst", bp_addr, 32'h0);
    stepCycle();
    applyStimulus(8'h04, 0);
    cmpVal("pause_after_rst", 32'(cmd_pause), 32'h1);
    stepCycle();

    $display("[TB] randomized byte stream");
    rand_ready = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) b = 8'($urandom_range(0, 255));
      else b = ops[$urandom_range(0, 7)];
      g = $urandom_range(0, 19);
      if (g == 19) g = TMO + 5;
      else if (g != 0) g = (g % 3) + 1;
      applyStimulus(b, g);
    end
    rand_ready = 1'b0;
    tx_ready = 1'b1;
    repeat (TMO + 5) stepCycle();

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
